// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
// Contents: func3 encodings, FSM state enum, latched-request struct and
// small func3 helper functions used by dmem_responder and load_ext.
package dmem_pkg;

  // RISC-V load/store func3 encodings (stores use the B/H/W codes)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Widest byte address the latched-request struct can carry.
  // DM_ADDRESS of the responder must be smaller than this.
  localparam int DM_ADDR_MAX = 16;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

  typedef struct packed {
    logic                   we;
    logic [DM_ADDR_MAX-1:0] addr;
    logic [31:0]            wdata;
    logic [2:0]             func3;
  } dmem_req_t;

  function automatic logic f3_supported(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Halfwords need an even address, words a multiple of four
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_H, F3_HU: return lo[0];
      F3_W:        return |lo;
      default:     return 1'b0;
    endcase
  endfunction

  // Clear the low address bits that would make the access misaligned
  function automatic logic [1:0] f3_align(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_H, F3_HU: return {lo[1], 1'b0};
      F3_W:        return 2'b00;
      default:     return lo;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_load_ext.sv
// load_ext: combinational load-result formatter.
// Ports:
//   i_raw      32-bit little-endian word read from a word-aligned address
//   i_addr_lo  byte offset of the access inside that word
//   i_func3    load func3 (LB/LH/LW/LBU/LHU); anything else yields 0
//   o_rdata    sign- or zero-extended load result
module load_ext
  import dmem_pkg::*;
(
  input  logic [31:0] i_raw,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_func3,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte  = i_raw[{i_addr_lo, 3'b000} +: 8];
    w_half  = i_addr_lo[1] ? i_raw[31:16] : i_raw[15:0];
    o_rdata = '0;
    case (i_func3)
      F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
      F3_W:    o_rdata = i_raw;
      F3_BU:   o_rdata = {24'd0, w_byte};
      F3_HU:   o_rdata = {16'd0, w_half};
      default: o_rdata = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle byte-addressed data memory with valid/ready
// request and response channels and programmable wait states.
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_req_valid / o_req_ready      request handshake
//   i_req_we, i_req_addr,
//   i_req_wdata, i_req_func3       store flag, byte address, store data, size/sign
//   o_rsp_valid / i_rsp_ready      response handshake
//   o_rsp_rdata, o_rsp_err         load result (0 for stores), access fault
// Build option: define DMEM_MISALIGN_TRAP_EN to fault misaligned halfword/word
// accesses; otherwise they are force-aligned and proceed normally.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DM_ADDRESS  = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [DM_ADDRESS-1:0] i_req_addr,
  input  logic [DATA_W-1:0]     i_req_wdata,
  input  logic [2:0]            i_req_func3,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_W-1:0]     o_rsp_rdata,
  output logic                  o_rsp_err
);

  localparam int         DEPTH     = 1 << DM_ADDRESS;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  dmem_state_t           r_state;
  dmem_state_t           w_next_state;
  logic [3:0]            r_count;
  logic                  r_req_ready;
  dmem_req_t             r_req;
  logic [DATA_W-1:0]     r_rdata;
  logic                  r_err;
  logic [7:0]            r_mem [DEPTH];

  logic                  w_accept;
  logic                  w_do_access;
  logic                  w_store;
  logic                  w_fault;
  logic                  w_acc_we;
  logic [DM_ADDRESS-1:0] w_acc_addr;
  logic [DATA_W-1:0]     w_acc_wdata;
  logic [2:0]            w_acc_func3;
  logic [1:0]            w_lo;
  logic [DM_ADDRESS-3:0] w_word;
  logic [DATA_W-1:0]     w_raw;
  logic [DATA_W-1:0]     w_load;
  logic [DATA_W-1:0]     w_wdata_sh;
  logic [3:0]            w_wmask;
  logic                  w_unused;

  assign w_accept = (r_state == IDLE) && r_req_ready && i_req_valid;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (r_count == 4'd0) w_next_state = RESP;
      RESP:    if (i_rsp_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // The access happens on the edge that enters RESP. With zero wait states
  // that is the accept edge itself, so the request is taken straight from
  // the inputs instead of the (not yet loaded) latch.
  assign w_do_access = (r_state != RESP) && (w_next_state == RESP);
  assign w_acc_we    = (r_state == IDLE) ? i_req_we    : r_req.we;
  assign w_acc_addr  = (r_state == IDLE) ? i_req_addr  : r_req.addr[DM_ADDRESS-1:0];
  assign w_acc_wdata = (r_state == IDLE) ? i_req_wdata : r_req.wdata;
  assign w_acc_func3 = (r_state == IDLE) ? i_req_func3 : r_req.func3;
  assign w_unused    = &{1'b0, r_req.addr[DM_ADDR_MAX-1:DM_ADDRESS]};

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_fault = !f3_supported(w_acc_func3) || f3_misaligned(w_acc_func3, w_acc_addr[1:0]);
  assign w_lo    = w_acc_addr[1:0];
`else
  assign w_fault = !f3_supported(w_acc_func3);
  assign w_lo    = f3_align(w_acc_func3, w_acc_addr[1:0]);
`endif

  // Aligned accesses never cross a word, so one word-aligned read covers all
  assign w_word = w_acc_addr[DM_ADDRESS-1:2];
  assign w_raw  = {r_mem[{w_word, 2'd3}], r_mem[{w_word, 2'd2}],
                   r_mem[{w_word, 2'd1}], r_mem[{w_word, 2'd0}]};

  load_ext u_load_ext (
    .i_raw     (w_raw),
    .i_addr_lo (w_lo),
    .i_func3   (w_acc_func3),
    .o_rdata   (w_load)
  );

  always_comb begin
    w_wmask = 4'b0000;
    case (w_acc_func3[1:0])
      2'b00:   w_wmask = 4'b0001 << w_lo;
      2'b01:   w_wmask = 4'b0011 << w_lo;
      2'b10:   w_wmask = 4'b1111;
      default: w_wmask = 4'b0000;
    endcase
  end

  assign w_wdata_sh = w_acc_wdata << {w_lo, 3'b000};
  assign w_store    = w_do_access && w_acc_we && !w_fault;

  // Memory contents survive reset
  always_ff @(posedge i_clk) begin
    if (w_store) begin
      for (int k = 0; k < 4; k++) begin
        if (w_wmask[k]) r_mem[{w_word, 2'(k)}] <= w_wdata_sh[8*k +: 8];
      end
    end
  end

  // req_ready is registered so it stays low during reset and rises one
  // cycle after release or after a response handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_req_ready <= 1'b0;
      r_count     <= 4'd0;
      r_req       <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_req_ready <= (w_next_state == IDLE);
      if (w_accept) begin
        r_req   <= '{we: i_req_we, addr: DM_ADDR_MAX'(i_req_addr),
                     wdata: i_req_wdata, func3: i_req_func3};
        r_count <= WAIT_LOAD;
      end else if ((r_state == WAIT) && (r_count != 4'd0)) begin
        r_count <= r_count - 4'd1;
      end
      if (w_do_access) begin
        r_rdata <= (w_acc_we || w_fault) ? '0 : w_load;
        r_err   <= w_fault;
      end
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = (r_state == RESP);
  assign o_rsp_rdata = r_rdata;
  assign o_rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: directed transactions with literal expected
// results, plus a transaction-level memory model checked every cycle.
module tb_dmem_responder;

  localparam int DM_ADDRESS  = 9;
  localparam int DATA_W      = 32;
  localparam int WAIT_CYCLES = 2;
  localparam int DEPTH       = 1 << DM_ADDRESS;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010;
  localparam logic [2:0] LBU = 3'b100, LHU = 3'b101;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        reqValid = 1'b0;
  logic        reqWe = 1'b0;
  logic [8:0]  reqAddr = '0;
  logic [31:0] reqWdata = '0;
  logic [2:0]  reqFunc3 = '0;
  logic        rspReady = 1'b0;
  logic        reqReady;
  logic        rspValid;
  logic [31:0] rspRdata;
  logic        rspErr;

  int checks = 0;
  int errors = 0;

  // model state
  logic [7:0]  modelMem [DEPTH];
  bit          modelPending = 0;
  bit          modelInResp = 0;
  bit          modelInReset = 1;
  bit          modelWasReady = 0;
  bit          checkEn = 0;
  int          modelEdges = 0;
  logic        mWe;
  int          mAddr;
  logic [31:0] mWdata;
  logic [2:0]  mF3;
  logic [31:0] expData = '0;
  logic        expErr = 1'b0;

  logic [31:0] rd;
  logic        er;

  dmem_responder #(
    .DM_ADDRESS  (DM_ADDRESS),
    .DATA_W      (DATA_W),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rstN),
    .i_req_valid (reqValid),
    .o_req_ready (reqReady),
    .i_req_we    (reqWe),
    .i_req_addr  (reqAddr),
    .i_req_wdata (reqWdata),
    .i_req_func3 (reqFunc3),
    .o_rsp_valid (rspValid),
    .i_rsp_ready (rspReady),
    .o_rsp_rdata (rspRdata),
    .o_rsp_err   (rspErr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte-level reference access: computes the response and updates modelMem
  task automatic modelAccess();
    int a;
    int n;
    bit sup;
    bit mis;
    bit bad;
    logic [31:0] v;
    a   = mAddr;
    sup = (mF3 == LB) || (mF3 == LH) || (mF3 == LW) || (mF3 == LBU) || (mF3 == LHU);
    n   = (mF3[1:0] == 2'b00) ? 1 : (mF3[1:0] == 2'b01) ? 2 : 4;
    mis = ((n == 2) && (a % 2 != 0)) || ((n == 4) && (a % 4 != 0));
`ifdef DMEM_MISALIGN_TRAP_EN
    bad = !sup || mis;
`else
    bad = !sup;
    if (sup) a = a - (a % n);
`endif
    expErr  = bad;
    expData = 32'd0;
    if (!bad) begin
      if (mWe) begin
        for (int k = 0; k < n; k++) modelMem[(a + k) % DEPTH] = mWdata[8*k +: 8];
      end else begin
        v = 32'd0;
        for (int k = 0; k < n; k++) v = v | (32'(modelMem[(a + k) % DEPTH]) << (8 * k));
        if (!mF3[2] && (n < 4) && v[8*n-1]) v = v | (32'hFFFFFFFF << (8 * n));
        expData = v;
      end
    end
  endtask

  // Model timeline, advanced on every rising edge
  initial begin
    for (int i = 0; i < DEPTH; i++) modelMem[i] = 8'h00;
    forever begin
      @(posedge clk);
      if (!rstN) begin
        modelPending = 0;
        modelInResp  = 0;
        modelInReset = 1;
      end else begin
        modelWasReady = !modelPending && !modelInReset;
        modelInReset  = 0;
        if (modelInResp && rspReady) begin
          modelPending = 0;
          modelInResp  = 0;
        end else if (modelPending && !modelInResp) begin
          modelEdges++;
          if (modelEdges >= WAIT_CYCLES) begin
            modelAccess();
            modelInResp = 1;
          end
        end
        if (modelWasReady && reqValid) begin
          mWe = reqWe; mAddr = int'(reqAddr); mWdata = reqWdata; mF3 = reqFunc3;
          modelPending = 1;
          modelEdges   = 0;
          if (WAIT_CYCLES == 0) begin
            modelAccess();
            modelInResp = 1;
          end
        end
      end
      checkEn = 1;
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (checkEn) begin
        checkOutput("rspValid", 32'(rspValid), 32'(modelInResp));
        checkOutput("reqReady", 32'(reqReady), 32'(!modelPending && !modelInReset));
        if (modelInResp) begin
          checkOutput("rspRdata", rspRdata, expData);
          checkOutput("rspErr", 32'(rspErr), 32'(expErr));
        end
      end
    end
  end

  task automatic applyStimulus(input logic we, input logic [8:0] addr, input logic [31:0] wdata,
                               input logic [2:0] f3, input int hold,
                               output logic [31:0] rdata, output logic err);
    bit got;
    int n;
    rdata = 32'd0;
    err   = 1'b0;
    @(negedge clk);
    reqValid = 1'b1; reqWe = we; reqAddr = addr; reqWdata = wdata; reqFunc3 = f3;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      if (reqReady) got = 1;
      else @(negedge clk);
    end
    if (!got) begin
      checkOutput("acceptTimeout", 32'd0, 32'd1);
      reqValid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 reqValid = 1'b0;
    n = 0;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      n++;
      if (rspValid) got = 1;
    end
    if (!got) begin
      checkOutput("responseTimeout", 32'd0, 32'd1);
      return;
    end
    checkOutput("latency", 32'(n), 32'(WAIT_CYCLES + 1));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("holdValid", 32'(rspValid), 32'd1);
      checkOutput("holdReqReady", 32'(reqReady), 32'd0);
    end
    rdata = rspRdata;
    err   = rspErr;
    rspReady = 1'b1;
    @(posedge clk);
    #1 rspReady = 1'b0;
  endtask

  task automatic expectResp(input string name, input logic [31:0] expR, input logic expE);
    checkOutput({name, ".rdata"}, rd, expR);
    checkOutput({name, ".err"}, 32'(er), 32'(expE));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("rstReqReady", 32'(reqReady), 32'd0);
    checkOutput("rstRspValid", 32'(rspValid), 32'd0);
    checkOutput("rstRdata", rspRdata, 32'd0);
    checkOutput("rstErr", 32'(rspErr), 32'd0);
    #2 rstN = 1'b1;
    @(negedge clk);
    checkOutput("relReqReady", 32'(reqReady), 32'd1);

    applyStimulus(1'b1, 9'h010, 32'h11223344, LW, 0, rd, er);
    expectResp("primeSW", 32'd0, 1'b0);

    // store interrupted by reset while waiting
    @(negedge clk);
    reqValid = 1'b1; reqWe = 1'b1; reqAddr = 9'h010; reqWdata = 32'hCAFEBABE; reqFunc3 = LW;
    checkOutput("midReqReady", 32'(reqReady), 32'd1);
    @(posedge clk);
    #1 reqValid = 1'b0;
    @(negedge clk);
    #2 rstN = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midRstRspValid", 32'(rspValid), 32'd0);
    checkOutput("midRstReqReady", 32'(reqReady), 32'd0);
    #2 rstN = 1'b1;
    @(negedge clk);
    checkOutput("midRelReqReady", 32'(reqReady), 32'd1);
    applyStimulus(1'b0, 9'h010, 32'd0, LW, 0, rd, er);
    expectResp("droppedSW", 32'h11223344, 1'b0);

    applyStimulus(1'b1, 9'h010, 32'hDEADBEEF, LW, 0, rd, er);
    expectResp("SW", 32'd0, 1'b0);
    applyStimulus(1'b0, 9'h010, 32'd0, LW, 0, rd, er);
    expectResp("LW", 32'hDEADBEEF, 1'b0);
    applyStimulus(1'b0, 9'h013, 32'd0, LB, 0, rd, er);
    expectResp("LB", 32'hFFFFFFDE, 1'b0);
    applyStimulus(1'b0, 9'h013, 32'd0, LBU, 0, rd, er);
    expectResp("LBU", 32'h000000DE, 1'b0);
    applyStimulus(1'b0, 9'h012, 32'd0, LH, 0, rd, er);
    expectResp("LH", 32'hFFFFDEAD, 1'b0);
    applyStimulus(1'b0, 9'h012, 32'd0, LHU, 0, rd, er);
    expectResp("LHU", 32'h0000DEAD, 1'b0);

    applyStimulus(1'b1, 9'h1FF, 32'h0000005A, LB, 0, rd, er);
    expectResp("SBtop", 32'd0, 1'b0);
    applyStimulus(1'b0, 9'h1FF, 32'd0, LBU, 0, rd, er);
    expectResp("LBUtop", 32'h0000005A, 1'b0);
    applyStimulus(1'b1, 9'h000, 32'hA5A5A5A5, LW, 0, rd, er);
    expectResp("SWzero", 32'd0, 1'b0);

`ifdef DMEM_MISALIGN_TRAP_EN
    applyStimulus(1'b0, 9'h011, 32'd0, LW, 0, rd, er);
    expectResp("misLW", 32'd0, 1'b1);
    applyStimulus(1'b1, 9'h1FE, 32'h01020304, LW, 0, rd, er);
    expectResp("misSW", 32'd0, 1'b1);
    applyStimulus(1'b0, 9'h1FF, 32'd0, LBU, 0, rd, er);
    expectResp("misSWnoWrite", 32'h0000005A, 1'b0);
    applyStimulus(1'b0, 9'h010, 32'd0, LW, 0, rd, er);
    expectResp("misLWnoChange", 32'hDEADBEEF, 1'b0);
`else
    applyStimulus(1'b0, 9'h011, 32'd0, LW, 0, rd, er);
    expectResp("alignLW", 32'hDEADBEEF, 1'b0);
    applyStimulus(1'b1, 9'h1FE, 32'h01020304, LW, 0, rd, er);
    expectResp("alignSW", 32'd0, 1'b0);
    applyStimulus(1'b0, 9'h1FC, 32'd0, LW, 0, rd, er);
    expectResp("alignSWread", 32'h01020304, 1'b0);
`endif
    applyStimulus(1'b0, 9'h000, 32'd0, LW, 0, rd, er);
    expectResp("noWrap", 32'hA5A5A5A5, 1'b0);

    applyStimulus(1'b1, 9'h012, 32'hFFFF1234, LH, 0, rd, er);
    expectResp("SH", 32'd0, 1'b0);
    applyStimulus(1'b0, 9'h010, 32'd0, LW, 5, rd, er);
    expectResp("bpLW", 32'h1234BEEF, 1'b0);
    applyStimulus(1'b0, 9'h010, 32'd0, 3'b011, 5, rd, er);
    expectResp("bpBadF3", 32'd0, 1'b1);
    applyStimulus(1'b1, 9'h010, 32'h00000000, 3'b111, 0, rd, er);
    expectResp("badStore", 32'd0, 1'b1);
    applyStimulus(1'b0, 9'h010, 32'd0, LW, 0, rd, er);
    expectResp("badStoreNoWrite", 32'h1234BEEF, 1'b0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder serving load/store requests issued by the pipeline MEM stage over a valid/ready request channel and a valid/ready response channel.
- Holds a byte-addressed store of 2^DM_ADDRESS bytes and applies RISC-V func3 byte-lane rules for LB/LH/LW/LBU/LHU and SB/SH/SW.
- Latency per access is programmable, so the pipeline stall and hazard logic can be exercised against a non-ideal memory.

Parameters:
- DM_ADDRESS, 9: byte address width; memory depth is 2^DM_ADDRESS bytes.
- DATA_W, 32: data width; fixed at 32.
- WAIT_CYCLES, 2: wait states between request accept and response valid (0..15).

Ports:
- clk  in  1  single clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  DM_ADDRESS  byte address.
- req_wdata  in  DATA_W  store data, right-aligned.
- req_func3  in  3  access size/sign (RISC-V load/store func3).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts response.
- rsp_rdata  out  DATA_W  load result, sign- or zero-extended; 0 for stores.
- rsp_err  out  1  access fault (see Optional Feature).

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
- Memory contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - A request is accepted on a cycle with req_valid & req_ready; addr, we, wdata and func3 are latched.
  - If WAIT_CYCLES=0, go to RESP; otherwise load counter=WAIT_CYCLES-1 and go to WAIT.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle; when counter==0, perform the access and go to RESP.
- RESP:
  - rsp_valid=1. rsp_rdata and rsp_err stay stable until rsp_valid & rsp_ready.
  - On handshake, go to IDLE; the next request can be accepted in the following cycle.
- Total latency is accept + WAIT_CYCLES + 1 cycles to rsp_valid.
- Memory access timing:
  - The store write and the load read both occur on the clock edge that enters RESP.
  - A load following a store to the same address returns the new data.
- Store byte lanes, using the latched address a:
  - SB (000): byte a <= wdata[7:0].
  - SH (001): bytes a, a+1 <= wdata[15:0], little-endian.
  - SW (010): bytes a..a+3 <= wdata.
- Load assembly, little-endian:
  - LB (000): sign-extend byte.
  - LH (001): sign-extend halfword.
  - LW (010): full word.
  - LBU (100): zero-extend byte.
  - LHU (101): zero-extend halfword.
- Unsupported func3 (011, 110, 111): no write, rsp_rdata=0, rsp_err=1.
- Address wrap: byte addresses a+k are taken modulo 2^DM_ADDRESS.
- Backpressure: req_valid asserted while not in IDLE is ignored. The requester must hold its request stable until accepted.
- Reset mid-operation: any in-flight access is dropped; a store not yet in RESP does not modify memory.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined:
  - Halfword access with a[0]!=0, or word access with a[1:0]!=0, is misaligned.
  - A misaligned access performs no write, returns rsp_rdata=0 and rsp_err=1, with the same latency as a normal access.
- Undefined:
  - Misaligned addresses are force-aligned: a[0] is cleared for halfwords, a[1:0] for words.
  - The access proceeds normally; rsp_err flags only unsupported func3.

Decomposition:
- Package dmem_pkg: func3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU); FSM enum dmem_state_t {IDLE, WAIT, RESP}; latched-request struct dmem_req_t {we, addr, wdata, func3}.
- Sub-module load_ext: combinational; takes a 32-bit raw word, the address low 2 bits and func3; outputs the extended rsp_rdata. Reused by the datapath for any future direct-load path.

Test Plan:
- Reset: hold reset=0 for 3 cycles mid-WAIT -> rsp_valid=0, req_ready=0; after release, req_ready=1 next cycle; the pending SW has no effect (a later LW returns the prior contents).
- SW 0xDEADBEEF @0x010, then LW @0x010 with WAIT_CYCLES=2 -> rsp_valid exactly 3 cycles after accept; rsp_rdata=0xDEADBEEF.
- LB/LBU/LH/LHU at @0x013 and @0x012 on that word -> 0xFFFFFFDE, 0x000000DE, 0xFFFFDEAD, 0x0000DEAD.
- SB 0x5A @0x1FF, then LBU @0x1FF -> 0x5A; SW @0x1FE with the macro undefined -> force-aligned to @0x1FC, no wrap.
- Misaligned LW @0x011 with DMEM_MISALIGN_TRAP_EN -> rsp_err=1, rsp_rdata=0, memory unchanged.
- Response backpressure: rsp_ready=0 for 5 cycles -> rsp_valid, rsp_rdata and rsp_err stable and req_ready=0 throughout; func3=011 -> rsp_err=1.
